// File: rtl/ysyx_25030081_lsu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ysyx_25030081_lsu_pkg
//  Brief    : Shared constants for the load/store unit: FSM state codes,
//             mem_op encodings, byte-lane masks and an op legality helper.
//  Revision : 1.0  initial release
// ============================================================================
package ysyx_25030081_lsu_pkg;

  // FSM state codes (2-bit)
  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_REQ  = 2'd1;
  localparam logic [1:0] C_ST_RESP = 2'd2;
  localparam logic [1:0] C_ST_DONE = 2'd3;

  // mem_op encodings: [2]=unsigned, [1]=word, [0]=half
  localparam logic [2:0] C_OP_B  = 3'b000;
  localparam logic [2:0] C_OP_H  = 3'b001;
  localparam logic [2:0] C_OP_W  = 3'b010;
  localparam logic [2:0] C_OP_BU = 3'b100;
  localparam logic [2:0] C_OP_HU = 3'b101;

  // Lane masks before shifting to the addressed byte
  localparam logic [3:0] C_MASK_B = 4'b0001;
  localparam logic [3:0] C_MASK_H = 4'b0011;
  localparam logic [3:0] C_MASK_W = 4'b1111;

  // Anything outside the five defined encodings is an illegal request
  function automatic logic op_illegal(input logic [2:0] op);
    return !((op == C_OP_B) || (op == C_OP_H) || (op == C_OP_W) ||
             (op == C_OP_BU) || (op == C_OP_HU));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25030081_lsu_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ysyx_25030081_lsu_align
//  Brief    : Combinational byte-lane formatting. Store side builds the write
//             mask, lane-replicated data and misalignment flag; load side
//             selects the addressed lane and sign/zero extends it.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_25030081_lsu_align
  import ysyx_25030081_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        st_op,
  input  logic [1:0]        st_addr_lo,
  input  logic [DATA_W-1:0] st_wdata,
  output logic [3:0]        st_wmask,
  output logic [DATA_W-1:0] st_wdata_rep,
  output logic              st_misaligned,
  input  logic [2:0]        ld_op,
  input  logic [1:0]        ld_addr_lo,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_rdata_ext
);

  logic [DATA_W-1:0] w_lane;

  // Store side: size is taken from op[1:0]; the unsigned bit does not matter
  always_comb begin
    st_wmask      = 4'b0000;
    st_wdata_rep  = st_wdata;
    st_misaligned = 1'b0;
    case (st_op[1:0])
      2'b00: begin
        st_wmask     = C_MASK_B << st_addr_lo;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      2'b01: begin
        st_wmask      = C_MASK_H << st_addr_lo;
        st_wdata_rep  = {2{st_wdata[15:0]}};
        st_misaligned = st_addr_lo[0];
      end
      2'b10: begin
        st_wmask      = C_MASK_W;
        st_misaligned = |st_addr_lo;
      end
      default: begin
        st_wmask      = 4'b0000;
        st_misaligned = 1'b0;
      end
    endcase
  end

  assign w_lane = ld_rdata >> {ld_addr_lo, 3'b000};

  // Load side: move the addressed lane to bit 0, then extend by op
  always_comb begin
    ld_rdata_ext = '0;
    case (ld_op)
      C_OP_B:  ld_rdata_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      C_OP_BU: ld_rdata_ext = {24'd0, w_lane[7:0]};
      C_OP_H:  ld_rdata_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      C_OP_HU: ld_rdata_ext = {16'd0, w_lane[15:0]};
      C_OP_W:  ld_rdata_ext = ld_rdata;
      default: ld_rdata_ext = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_25030081_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ysyx_25030081_lsu
//  Brief    : Load/store unit. Accepts one decoded request, checks alignment,
//             runs one valid/ready bus transaction and returns the extended
//             load result or store completion to writeback.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_25030081_lsu
  import ysyx_25030081_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_ren,
  input  logic              in_wen,
  input  logic [2:0]        in_mem_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wen,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wmask,
  input  logic              bus_resp_valid,
  output logic              bus_resp_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_resp_err
);

  logic [1:0]        r_state;
  logic              r_wen;
  logic [2:0]        r_op;
  logic [1:0]        r_addr_lo;

  logic [3:0]        w_wmask;
  logic [DATA_W-1:0] w_wdata_rep;
  logic              w_misaligned;
  logic [DATA_W-1:0] w_rdata_ext;
  logic              w_bad_req;

  // Store formatting works on the live request; load extension on the latched one
  ysyx_25030081_lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .st_op         (in_mem_op),
    .st_addr_lo    (in_addr[1:0]),
    .st_wdata      (in_wdata),
    .st_wmask      (w_wmask),
    .st_wdata_rep  (w_wdata_rep),
    .st_misaligned (w_misaligned),
    .ld_op         (r_op),
    .ld_addr_lo    (r_addr_lo),
    .ld_rdata      (bus_rdata),
    .ld_rdata_ext  (w_rdata_ext)
  );

  assign w_bad_req = op_illegal(in_mem_op) | (in_ren & in_wen) | w_misaligned;

  // Handshake outputs are pure state decodes
  assign in_ready       = (r_state == C_ST_IDLE);
  assign bus_req_valid  = (r_state == C_ST_REQ);
  assign bus_resp_ready = (r_state == C_ST_RESP);
  assign out_valid      = (r_state == C_ST_DONE);

  // Request latching, bus field registers, result capture and state sequencing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= C_ST_IDLE;
      r_wen     <= 1'b0;
      r_op      <= 3'b000;
      r_addr_lo <= 2'b00;
      bus_addr  <= '0;
      bus_wen   <= 1'b0;
      bus_wdata <= '0;
      bus_wmask <= 4'b0000;
      out_rdata <= '0;
      out_err   <= 1'b0;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (in_valid) begin
            r_wen     <= in_wen;
            r_op      <= in_mem_op;
            r_addr_lo <= in_addr[1:0];
            if (w_bad_req) begin
              out_err   <= 1'b1;
              out_rdata <= '0;
              r_state   <= C_ST_DONE;
            end else if (!in_ren && !in_wen) begin
              out_err   <= 1'b0;
              out_rdata <= '0;
              r_state   <= C_ST_DONE;
            end else begin
              bus_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
              bus_wen   <= in_wen;
              bus_wdata <= in_wen ? w_wdata_rep : '0;
              bus_wmask <= in_wen ? w_wmask : 4'b0000;
              r_state   <= C_ST_REQ;
            end
          end
        end
        C_ST_REQ: begin
          if (bus_req_ready) begin
            r_state <= C_ST_RESP;
          end
        end
        C_ST_RESP: begin
          if (bus_resp_valid) begin
            out_err   <= bus_resp_err;
            out_rdata <= (r_wen || bus_resp_err) ? '0 : w_rdata_ext;
            r_state   <= C_ST_DONE;
          end
        end
        C_ST_DONE: begin
          if (out_ready) begin
            r_state <= C_ST_IDLE;
          end
        end
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25030081_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_25030081_lsu
//  Brief    : Self-checking bench for the load/store unit: directed cases plus
//             randomized requests against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_25030081_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_ren, in_wen;
  logic [2:0]  in_mem_op;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        bus_req_valid, bus_req_ready, bus_wen;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wmask;
  logic        bus_resp_valid, bus_resp_ready, bus_resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_25030081_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
    .in_mem_op(in_mem_op), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_resp_valid(bus_resp_valid), .bus_resp_ready(bus_resp_ready),
    .bus_rdata(bus_rdata), .bus_resp_err(bus_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes
  function automatic int size_of(input logic [2:0] op);
    return op[1] ? 4 : (op[0] ? 2 : 1);
  endfunction

  function automatic logic model_bad(input logic ren, input logic wen,
                                     input logic [2:0] op, input logic [1:0] lo);
    logic legal;
    logic mis;
    legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
    mis   = legal && ((int'(lo) % size_of(op)) != 0);
    return !legal || (ren && wen) || mis;
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] op, input logic [1:0] lo);
    int m;
    m = ((1 << size_of(op)) - 1) << lo;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
    case (size_of(op))
      1:       return wd[7:0] * 32'h01010101;
      2:       return wd[15:0] * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] lo,
                                             input logic [31:0] rd);
    int nb;
    logic [31:0] v;
    logic [31:0] m;
    nb = size_of(op);
    if (nb == 4) return rd;
    m = (32'd1 << (8 * nb)) - 32'd1;
    v = (rd >> (8 * lo)) & m;
    if (!op[2] && v[8 * nb - 1]) v = v | ~m;
    return v;
  endfunction

  // One complete request from accept to writeback handshake
  task automatic txn(input logic ren, input logic wen, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rresp, input logic rerr,
                     input int req_dly, input int resp_dly, input int out_dly,
                     input logic stray);
    logic        bad, use_bus, exp_err;
    logic [31:0] exp_rd, exp_addr;
    logic [3:0]  exp_mask;
    bad      = model_bad(ren, wen, op, addr[1:0]);
    use_bus  = !bad && (ren || wen);
    exp_addr = addr & 32'hFFFF_FFFC;
    exp_mask = wen ? model_mask(op, addr[1:0]) : 4'b0000;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_ren = ren; in_wen = wen; in_mem_op = op; in_addr = addr; in_wdata = wd;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_ren = $urandom; in_wen = $urandom; in_mem_op = $urandom;
    in_addr = $urandom; in_wdata = $urandom;
    if (use_bus) begin
      for (int i = 0; i <= req_dly; i++) begin
        chk("req_valid", {31'd0, bus_req_valid}, 32'd1);
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_wen", {31'd0, bus_wen}, {31'd0, wen});
        chk("bus_wmask", {28'd0, bus_wmask}, {28'd0, exp_mask});
        if (wen) chk("bus_wdata", bus_wdata, model_wdata(op, wd));
        chk("resp_ready_req", {31'd0, bus_resp_ready}, 32'd0);
        bus_req_ready  = (i == req_dly);
        bus_resp_valid = stray ? 1'($urandom) : 1'b0;
        bus_rdata      = $urandom;
        bus_resp_err   = 1'($urandom);
        step();
      end
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b0;
      for (int i = 0; i <= resp_dly; i++) begin
        chk("resp_ready", {31'd0, bus_resp_ready}, 32'd1);
        chk("req_valid_resp", {31'd0, bus_req_valid}, 32'd0);
        chk("out_valid_resp", {31'd0, out_valid}, 32'd0);
        bus_resp_valid = (i == resp_dly);
        bus_rdata      = (i == resp_dly) ? rresp : $urandom;
        bus_resp_err   = (i == resp_dly) ? rerr : 1'b1;
        step();
      end
      bus_resp_valid = 1'b0;
      bus_resp_err   = 1'b0;
      exp_err = rerr;
      exp_rd  = (wen || rerr) ? 32'd0 : model_load(op, addr[1:0], rresp);
    end else begin
      chk("no_bus_req", {31'd0, bus_req_valid}, 32'd0);
      exp_err = bad;
      exp_rd  = 32'd0;
    end
    for (int i = 0; i <= out_dly; i++) begin
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("out_rdata", out_rdata, exp_rd);
      chk("out_err", {31'd0, out_err}, {31'd0, exp_err});
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      chk("req_valid_done", {31'd0, bus_req_valid}, 32'd0);
      out_ready = (i == out_dly);
      step();
    end
    out_ready = 1'b0;
    chk("out_valid_after", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [2:0] rop;
    rst_n = 1'b0; in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_mem_op = 3'd0;
    in_addr = 32'd0; in_wdata = 32'd0; out_ready = 1'b0; bus_req_ready = 1'b0;
    bus_resp_valid = 1'b0; bus_rdata = 32'd0; bus_resp_err = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, bus_req_valid}, 32'd0);
    chk("rst_resp_ready", {31'd0, bus_resp_ready}, 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wen", {31'd0, bus_wen}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_wmask", {28'd0, bus_wmask}, 32'd0);
    rst_n = 1'b1;
    step();

    // Directed cases
    txn(1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'h1234_5678, 32'd0, 1'b0, 0, 0, 0, 1'b0);
    txn(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'd0, 1'b0, 0, 0, 0, 1'b0);
    txn(1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'd0, 32'h0000_8000, 1'b0, 0, 0, 0, 1'b0);
    txn(1'b1, 1'b0, 3'b100, 32'h8000_0001, 32'd0, 32'h0000_8000, 1'b0, 0, 0, 0, 1'b0);
    txn(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'd0, 32'h8001_0000, 1'b0, 0, 0, 0, 1'b0);
    txn(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'd0, 32'd0, 1'b0, 0, 0, 0, 1'b0);
    txn(1'b1, 1'b0, 3'b001, 32'h8000_0001, 32'd0, 32'd0, 1'b0, 0, 0, 0, 1'b0);
    txn(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'd0, 32'hDEAD_BEEF, 1'b1, 5, 3, 2, 1'b1);
    txn(1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 0, 0, 0, 1'b0);
    txn(1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 0, 0, 1, 1'b0);
    txn(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 0, 0, 0, 1'b0);

    // Reset during REQ drops bus_req_valid on that edge
    in_ren = 1'b1; in_wen = 1'b0; in_mem_op = 3'b010; in_addr = 32'h8000_0020; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rstreq_pre", {31'd0, bus_req_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("rstreq_req_valid", {31'd0, bus_req_valid}, 32'd0);
    chk("rstreq_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Reset during RESP abandons the transaction; a late response is ignored
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
    chk("rstresp_pre", {31'd0, bus_resp_ready}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstresp_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rstresp_resp_ready", {31'd0, bus_resp_ready}, 32'd0);
    bus_resp_valid = 1'b1; bus_rdata = 32'h1111_2222;
    step();
    bus_resp_valid = 1'b0;
    chk("late_resp_out_valid", {31'd0, out_valid}, 32'd0);
    chk("late_resp_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("late_resp_out_valid2", {31'd0, out_valid}, 32'd0);

    // Randomized requests, biased towards legal ops
    for (int n = 0; n < 300; n++) begin
      rop = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 2)) | (($urandom % 2 == 1) ? 3'b100 : 3'b000)
                                        : 3'($urandom);
      if (rop == 3'b110) rop = ($urandom % 2 == 1) ? 3'b110 : 3'b010;
      txn(1'($urandom), 1'($urandom), rop, $urandom, $urandom, $urandom,
          ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 2), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
